// File: rtl/fp_factorial_sequencer_if.sv
// Handshake and multiplier bus for fp_factorial_sequencer.
// slave  : the sequencer (drives busy/done/result/flags and the multiplier operands)
// master : the requester plus the attached floating-point multiplier
//   start_in/n_in            request to compute n_in!
//   busy_out/done_out        run status and one-cycle completion pulse
//   result_out               last result, {sign, exponent, mantissa}
//   overflow_out/underflow_out sticky multiplier flags for the current run
//   mul_a_out/mul_b_out      operands to the multiplier
//   mul_p_in/mul_of_in/mul_uf_in combinational product and flags back
interface fp_factorial_sequencer_if #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned N_WIDTH        = 6
);
  localparam int unsigned W = 1 + EXP_WIDTH + MANTISSA_WIDTH;

  logic               start_in;
  logic [N_WIDTH-1:0] n_in;
  logic               busy_out;
  logic               done_out;
  logic [W-1:0]       result_out;
  logic               overflow_out;
  logic               underflow_out;
  logic [W-1:0]       mul_a_out;
  logic [W-1:0]       mul_b_out;
  logic [W-1:0]       mul_p_in;
  logic               mul_of_in;
  logic               mul_uf_in;

  modport master (
    output start_in, n_in, mul_p_in, mul_of_in, mul_uf_in,
    input  busy_out, done_out, result_out, overflow_out, underflow_out, mul_a_out, mul_b_out
  );

  modport slave (
    input  start_in, n_in, mul_p_in, mul_of_in, mul_uf_in,
    output busy_out, done_out, result_out, overflow_out, underflow_out, mul_a_out, mul_b_out
  );
endinterface

// File: rtl/fp_factorial_sequencer.sv
// Floating-point factorial sequencer. Computes n! by repeatedly multiplying an
// accumulator by the float of a counter k = 2..n through an external
// combinational multiplier. A multiplier overflow aborts the run early.
// Ports:
//   clk_in    clock, rising edge
//   rst_n_in  synchronous active-low reset
//   bus       fp_factorial_sequencer_if.slave (request, status, result, multiplier bus)
module fp_factorial_sequencer #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned N_WIDTH        = 6
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  fp_factorial_sequencer_if.slave bus
);

  localparam int unsigned W    = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int unsigned BIAS = (2 ** (EXP_WIDTH - 1)) - 1;
  localparam logic [W-1:0] FP_ONE = {1'b0, EXP_WIDTH'(BIAS), MANTISSA_WIDTH'(0)};

  typedef enum logic [0:0] {StIdle, StMult} state_e;

  state_e             state_q;
  logic [W-1:0]       acc_q;
  logic [N_WIDTH-1:0] k_q;
  logic [N_WIDTH-1:0] n_reg_q;
  logic               busy_q;
  logic               done_q;
  logic [W-1:0]       result_q;
  logic               overflow_q;
  logic               underflow_q;

  // Exact integer-to-float of k: the counter never exceeds the mantissa width
  // plus the hidden bit, so no rounding is needed.
  int unsigned           lead;
  logic [MANTISSA_WIDTH:0] k_ext;
  logic [MANTISSA_WIDTH:0] k_shift;
  logic [W-1:0]          k_fp;

  always_comb begin
    lead = 0;
    for (int i = 0; i < int'(N_WIDTH); i++) begin
      if (k_q[i]) lead = unsigned'(i);
    end
    k_ext   = (MANTISSA_WIDTH + 1)'(k_q);
    k_shift = k_ext << (MANTISSA_WIDTH - lead);
    if (k_q == '0) begin
      k_fp = '0;
    end else begin
      k_fp = {1'b0, EXP_WIDTH'(BIAS + lead), k_shift[MANTISSA_WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      k_q         <= '0;
      n_reg_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start_in) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            if (bus.n_in <= N_WIDTH'(1)) begin
              // 0! and 1! need no multiplications.
              result_q <= FP_ONE;
              done_q   <= 1'b1;
            end else begin
              acc_q   <= FP_ONE;
              k_q     <= N_WIDTH'(2);
              n_reg_q <= bus.n_in;
              busy_q  <= 1'b1;
              state_q <= StMult;
            end
          end
        end
        StMult: begin
          acc_q       <= bus.mul_p_in;
          overflow_q  <= overflow_q | bus.mul_of_in;
          underflow_q <= underflow_q | bus.mul_uf_in;
          if ((k_q == n_reg_q) || bus.mul_of_in) begin
            result_q <= bus.mul_p_in;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end else begin
            k_q <= k_q + N_WIDTH'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
  assign bus.result_out    = result_q;
  assign bus.overflow_out  = overflow_q;
  assign bus.underflow_out = underflow_q;
  assign bus.mul_a_out     = acc_q;
  assign bus.mul_b_out     = k_fp;

endmodule

// File: tb/tb_fp_factorial_sequencer.sv
// Directed bench for fp_factorial_sequencer with an IEEE single-precision
// round-to-nearest-even multiplier model attached to the multiplier bus.
module tb_fp_factorial_sequencer;

  logic clk;
  logic rst_n;
  logic uf_inject;
  logic [33:0] mres;
  int errors;
  int checks;

  fp_factorial_sequencer_if #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .N_WIDTH(6)) bus ();

  fp_factorial_sequencer #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .N_WIDTH(6)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {overflow, underflow, product}; normal operands only, zero in -> zero out.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] prod;
    logic [24:0] m;
    logic        g;
    logic        s;
    logic        sgn;
    int          e;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, sgn, 31'd0};
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      m = {1'b0, prod[47:24]}; g = prod[23]; s = |prod[22:0]; e = e + 1;
    end else begin
      m = {1'b0, prod[46:23]}; g = prod[22]; s = |prod[21:0];
    end
    if (g && (s || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1; e = e + 1;
    end
    if (e >= 255) return {2'b10, sgn, 8'hFF, 23'd0};
    if (e <= 0) return {2'b01, sgn, 31'd0};
    return {2'b00, sgn, e[7:0], m[22:0]};
  endfunction

  always_comb mres = fmul(bus.mul_a_out, bus.mul_b_out);
  assign bus.mul_p_in  = mres[31:0];
  assign bus.mul_of_in = mres[33];
  assign bus.mul_uf_in = mres[32] | uf_inject;

  // Issues one start at a negedge and waits for done. lat counts rising edges
  // after the start-sampling edge up to the one that raised done (0 for n<=1).
  // glitch_at re-pulses start with n=3 at that wait step; uf_at injects underflow.
  task automatic run_fact(input logic [5:0] n, input int glitch_at, input int uf_at,
                          output int lat, output logic [31:0] first_b,
                          output logic [31:0] last_b, output logic first_busy);
    bus.n_in = n;
    bus.start_in = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start_in = 1'b0;
    lat = 0;
    first_b = bus.mul_b_out;
    last_b = bus.mul_b_out;
    first_busy = bus.busy_out;
    while (!bus.done_out && lat < 200) begin
      if (lat == glitch_at) begin
        bus.start_in = 1'b1; bus.n_in = 6'd3;
      end else begin
        bus.start_in = 1'b0;
      end
      uf_inject = (lat == uf_at);
      last_b = bus.mul_b_out;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    bus.start_in = 1'b0;
    uf_inject = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_in = 1'b0;
    bus.n_in = 6'd0;
    uf_inject = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_out); end
    checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done_out); end
    checks++; if (bus.result_out !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result_out); end
    checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL reset_of got=%b exp=0", bus.overflow_out); end
    checks++; if (bus.underflow_out !== 1'b0) begin errors++; $display("FAIL reset_uf got=%b exp=0", bus.underflow_out); end
    checks++; if (bus.mul_a_out !== 32'h0) begin errors++; $display("FAIL reset_mul_a got=%h exp=0", bus.mul_a_out); end
    checks++; if (bus.mul_b_out !== 32'h0) begin errors++; $display("FAIL reset_mul_b got=%h exp=0", bus.mul_b_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_small_n();
    int lat; logic [31:0] fb, lb; logic fbusy;
    for (int n = 0; n < 2; n++) begin
      run_fact(6'(n), -1, -1, lat, fb, lb, fbusy);
      checks++; if (lat !== 0) begin errors++; $display("FAIL small_lat n=%0d got=%0d exp=0", n, lat); end
      checks++; if (bus.result_out !== 32'h3F800000) begin errors++; $display("FAIL small_result n=%0d got=%h exp=3f800000", n, bus.result_out); end
      checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL small_busy n=%0d got=%b exp=0", n, bus.busy_out); end
      @(negedge clk);
      checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL small_pulse n=%0d got=%b exp=0", n, bus.done_out); end
    end
  endtask

  task automatic test_n5();
    int lat; logic [31:0] fb, lb; logic fbusy;
    run_fact(6'd5, -1, -1, lat, fb, lb, fbusy);
    checks++; if (lat !== 4) begin errors++; $display("FAIL n5_lat got=%0d exp=4", lat); end
    checks++; if (bus.result_out !== 32'h42F00000) begin errors++; $display("FAIL n5_result got=%h exp=42f00000", bus.result_out); end
    checks++; if (fbusy !== 1'b1) begin errors++; $display("FAIL n5_busy got=%b exp=1", fbusy); end
    checks++; if (fb !== 32'h40000000) begin errors++; $display("FAIL n5_first_b got=%h exp=40000000", fb); end
    checks++; if (lb !== 32'h40A00000) begin errors++; $display("FAIL n5_last_b got=%h exp=40a00000", lb); end
    checks++; if ({bus.overflow_out, bus.underflow_out} !== 2'b00) begin errors++; $display("FAIL n5_flags got=%b exp=00", {bus.overflow_out, bus.underflow_out}); end
    @(negedge clk);
    checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL n5_pulse got=%b exp=0", bus.done_out); end
    checks++; if (bus.result_out !== 32'h42F00000) begin errors++; $display("FAIL n5_hold got=%h exp=42f00000", bus.result_out); end
  endtask

  task automatic test_n10();
    int lat; logic [31:0] fb, lb; logic fbusy;
    run_fact(6'd10, -1, -1, lat, fb, lb, fbusy);
    checks++; if (lat !== 9) begin errors++; $display("FAIL n10_lat got=%0d exp=9", lat); end
    checks++; if (bus.result_out !== 32'h4A5D7C00) begin errors++; $display("FAIL n10_result got=%h exp=4a5d7c00", bus.result_out); end
    checks++; if (lb !== 32'h41200000) begin errors++; $display("FAIL n10_last_b got=%h exp=41200000", lb); end
    checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL n10_of got=%b exp=0", bus.overflow_out); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] fb, lb; logic fbusy;
    run_fact(6'd40, -1, -1, lat, fb, lb, fbusy);
    checks++; if (lat !== 34) begin errors++; $display("FAIL of_lat got=%0d exp=34", lat); end
    checks++; if (bus.overflow_out !== 1'b1) begin errors++; $display("FAIL of_flag got=%b exp=1", bus.overflow_out); end
    checks++; if (bus.result_out !== 32'h7F800000) begin errors++; $display("FAIL of_result got=%h exp=7f800000", bus.result_out); end
    checks++; if (lb !== 32'h420C0000) begin errors++; $display("FAIL of_abort_k got=%h exp=420c0000", lb); end
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL of_busy got=%b exp=0", bus.busy_out); end
    @(negedge clk);
    checks++; if (bus.overflow_out !== 1'b1) begin errors++; $display("FAIL of_sticky got=%b exp=1", bus.overflow_out); end
    checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL of_pulse got=%b exp=0", bus.done_out); end
  endtask

  task automatic test_ignore_start();
    int lat; int extra; logic [31:0] fb, lb; logic fbusy;
    run_fact(6'd5, 1, -1, lat, fb, lb, fbusy);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ign_lat got=%0d exp=4", lat); end
    checks++; if (bus.result_out !== 32'h42F00000) begin errors++; $display("FAIL ign_result got=%h exp=42f00000", bus.result_out); end
    checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL ign_of_cleared got=%b exp=0", bus.overflow_out); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done_out || bus.busy_out) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ign_single_done got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid_run();
    int lat; int seen; logic [31:0] fb, lb; logic fbusy;
    bus.n_in = 6'd10;
    bus.start_in = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done_out) seen++;
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    if (bus.done_out) seen++;
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy_out); end
    checks++; if (bus.result_out !== 32'h0) begin errors++; $display("FAIL rstmid_result got=%h exp=0", bus.result_out); end
    checks++; if (bus.mul_a_out !== 32'h0) begin errors++; $display("FAIL rstmid_mul_a got=%h exp=0", bus.mul_a_out); end
    checks++; if (bus.mul_b_out !== 32'h0) begin errors++; $display("FAIL rstmid_mul_b got=%h exp=0", bus.mul_b_out); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done_out) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
    run_fact(6'd5, -1, -1, lat, fb, lb, fbusy);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_rerun_lat got=%0d exp=4", lat); end
    checks++; if (bus.result_out !== 32'h42F00000) begin errors++; $display("FAIL rstmid_rerun got=%h exp=42f00000", bus.result_out); end
    @(negedge clk);
  endtask

  task automatic test_underflow_sticky();
    int lat; logic [31:0] fb, lb; logic fbusy;
    run_fact(6'd4, -1, 1, lat, fb, lb, fbusy);
    checks++; if (lat !== 3) begin errors++; $display("FAIL uf_lat got=%0d exp=3", lat); end
    checks++; if (bus.underflow_out !== 1'b1) begin errors++; $display("FAIL uf_flag got=%b exp=1", bus.underflow_out); end
    checks++; if (bus.result_out !== 32'h41C00000) begin errors++; $display("FAIL uf_result got=%h exp=41c00000", bus.result_out); end
    @(negedge clk);
    checks++; if (bus.underflow_out !== 1'b1) begin errors++; $display("FAIL uf_held got=%b exp=1", bus.underflow_out); end
    run_fact(6'd3, -1, -1, lat, fb, lb, fbusy);
    checks++; if (bus.underflow_out !== 1'b0) begin errors++; $display("FAIL uf_cleared got=%b exp=0", bus.underflow_out); end
    checks++; if (bus.result_out !== 32'h40C00000) begin errors++; $display("FAIL uf_next_result got=%h exp=40c00000", bus.result_out); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] fb, lb; logic fbusy;
    run_fact(6'd2, -1, -1, lat, fb, lb, fbusy);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_n2_lat got=%0d exp=1", lat); end
    checks++; if (bus.result_out !== 32'h40000000) begin errors++; $display("FAIL b2b_n2 got=%h exp=40000000", bus.result_out); end
    // Next start issued in the same cycle done is visible; the block is already idle.
    run_fact(6'd3, -1, -1, lat, fb, lb, fbusy);
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_n3_lat got=%0d exp=2", lat); end
    checks++; if (bus.result_out !== 32'h40C00000) begin errors++; $display("FAIL b2b_n3 got=%h exp=40c00000", bus.result_out); end
    checks++; if (fb !== 32'h40000000) begin errors++; $display("FAIL b2b_first_b got=%h exp=40000000", fb); end
    checks++; if (lb !== 32'h40400000) begin errors++; $display("FAIL b2b_last_b got=%h exp=40400000", lb); end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    uf_inject = 1'b0;
    bus.start_in = 1'b0;
    bus.n_in = 6'd0;
    @(negedge clk);
    test_reset();
    test_small_n();
    test_n5();
    test_n10();
    test_overflow();
    test_ignore_start();
    test_reset_mid_run();
    test_underflow_sticky();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
